vector_list_sequencer: RTL and testbench
========================================

Name: vector_list_sequencer

Overview:
- Stores a display list of vector commands in internal RAM and walks it every frame.
- Drives the line-draw `control` unit through its x/y/draw/jump/ready interface.
- Owns command sequencing, the drawer handshake, frame wrap-around and frame-rate pacing.
- Replaces ad-hoc top-level state machines that sequence the drawer directly.

Parameters:
- DEPTH, 256, display-list entries (power of two).
- AW, 8, address width, log2(DEPTH).
- FRAME_CYCLES, 200000, minimum clk cycles from one frame start to the next (≥1).
- ACK_TIMEOUT, 16, max cycles to wait for ready to fall after a strobe.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe into list RAM.
- wr_addr  in  AW  host write address.
- wr_data  in  26  entry: [25:24] op, [23:12] x, [11:0] y.
- run  in  1  level; 1 = execute frames continuously.
- ready  in  1  drawer ready (1 = idle, accepts a command).
- x  out  12  target x to drawer.
- y  out  12  target y to drawer.
- draw  out  1  one-cycle draw strobe.
- jump  out  1  one-cycle jump (blanked move) strobe.
- busy  out  1  1 whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at end of each frame's list.
- frame_count  out  16  frames completed, wraps 0xFFFF→0.
- ack_timeout  out  1  sticky flag, set on handshake timeout.

Behaviour:
- Reset (reset=0, async): all outputs 0, addr=0, frame timer=0, state IDLE. RAM contents undefined/unchanged.
- RAM: one write port, one synchronous read port with 1-cycle latency. Host writes are accepted in any state, with no hazard protection. An entry rewritten before it is fetched takes effect this frame.
- Op codes: 00 END, 01 JUMP, 10 DRAW, 11 NOP.
- States:
  - IDLE: if run=1 → FETCH, addr=0, frame timer cleared to 0.
  - FETCH: present addr to RAM → DECODE next cycle.
  - DECODE: data valid.
    - END → EOF.
    - NOP → ADVANCE.
    - JUMP/DRAW → ISSUE; latch x/y from entry.
  - ISSUE: wait for ready=1. In that cycle assert jump (op 01) or draw (op 10) for exactly one cycle → WAIT_ACK, ack counter=0. x/y hold until the next ISSUE.
  - WAIT_ACK:
    - ready=0 → WAIT_DONE.
    - ready still 1 after ACK_TIMEOUT cycles → set ack_timeout, → ADVANCE. The command counts as done.
  - WAIT_DONE: ready=1 → ADVANCE.
  - ADVANCE:
    - addr==DEPTH-1 → EOF (implicit END, no wrap into entry 0 mid-frame).
    - Otherwise addr+1 → FETCH.
    - If run=0 here → IDLE instead.
  - EOF: frame_done=1 for one cycle, frame_count+1 → FRAME_WAIT.
  - FRAME_WAIT:
    - run=0 → IDLE.
    - Else when frame timer ≥ FRAME_CYCLES → addr=0, timer=0, → FETCH.
- Frame timer: increments every cycle when not IDLE, saturating at its max.
- Frame length: a frame longer than FRAME_CYCLES restarts immediately after EOF, with 1 cycle in FRAME_WAIT.
- Strobe/command order: one command in flight at a time. No strobe while ready=0 or while in WAIT states.
- Stopping: run falling mid-command does not abort. The current handshake completes; the stop takes effect at ADVANCE or FRAME_WAIT.
- Empty list: entry 0 = END gives frame_done every FRAME_CYCLES cycles and no strobes.
- Reset mid-handshake: draw/jump drop immediately; the drawer is reset by the same reset net.

Test Plan:
- Load [0]=JUMP(50,0), [1]=DRAW(0,40), [2]=DRAW(50,50), [3]=END. Run with a drawer model (ready low for 10 cycles per command) → strobes jump, draw, draw with those x/y in order. Each strobe is 1 cycle with ready=1; frame_done pulses once; frame_count=1.
- FRAME_CYCLES=100, same list, run held → second frame's jump strobe occurs exactly when the frame timer reaches 100 cycles after frame start; frame_count increments each frame.
- Drawer model never drops ready, ACK_TIMEOUT=16 → ack_timeout=1 after 16 cycles; the sequencer advances to the next entry; the flag stays set until reset.
- List of DEPTH DRAW entries, no END → after entry DEPTH-1 completes, frame_done pulses and the next fetch is addr 0 after pacing.
- Drop run during WAIT_DONE of entry 1 → entry 1 completes, no strobe for entry 2, busy=0 within 2 cycles after ready rises.
- Assert reset during WAIT_ACK → x=y=0, draw=jump=0, busy=0, frame_count=0 immediately; run=1 after release restarts from addr 0.

Source files
------------

// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: walks a RAM of vector commands each frame and feeds
// the line-draw unit one command at a time, paced to a minimum frame period.
module vector_list_sequencer #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned AW           = 8,
  parameter int unsigned FRAME_CYCLES = 200000,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [25:0]   wr_data,
  input  logic          run,
  input  logic          ready,
  output logic [11:0]   x,
  output logic [11:0]   y,
  output logic          draw,
  output logic          jump,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          ack_timeout
);

  localparam int unsigned TW  = $clog2(FRAME_CYCLES + 1);
  localparam int unsigned AKW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    OP_END  = 2'b00,
    OP_JUMP = 2'b01,
    OP_DRAW = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [11:0] x;
    logic [11:0] y;
  } entry_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_ADVANCE,
    S_EOF,
    S_FRAME_WAIT
  } state_e;

  entry_t mem [DEPTH];
  entry_t rd_q;

  state_e         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [AKW-1:0] ack_cnt_q, ack_cnt_d;
  op_e            op_q, op_d;
  logic [11:0]    x_q, x_d;
  logic [11:0]    y_q, y_d;
  logic           draw_q, draw_d;
  logic           jump_q, jump_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           ack_timeout_q, ack_timeout_d;

  // List RAM: host write port plus a registered read of the current address
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= entry_t'(wr_data);
    end
    rd_q <= mem[addr_q];
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      timer_q       <= '0;
      ack_cnt_q     <= '0;
      op_q          <= OP_END;
      x_q           <= '0;
      y_q           <= '0;
      draw_q        <= 1'b0;
      jump_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      timer_q       <= timer_d;
      ack_cnt_q     <= ack_cnt_d;
      op_q          <= op_d;
      x_q           <= x_d;
      y_q           <= y_d;
      draw_q        <= draw_d;
      jump_q        <= jump_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      ack_timeout_q <= ack_timeout_d;
    end
  end

  // Next-state, command handshake, frame pacing and output decode
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    timer_d       = timer_q;
    ack_cnt_d     = ack_cnt_q;
    op_d          = op_q;
    x_d           = x_q;
    y_d           = y_q;
    draw_d        = 1'b0;
    jump_d        = 1'b0;
    frame_count_d = frame_count_q;
    ack_timeout_d = ack_timeout_q;

    // Frame timer counts every active cycle and saturates
    if ((state_q != S_IDLE) && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          addr_d  = '0;
          timer_d = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (rd_q.op)
          OP_END:  state_d = S_EOF;
          OP_NOP:  state_d = S_ADVANCE;
          default: begin
            state_d = S_ISSUE;
            op_d    = rd_q.op;
            x_d     = rd_q.x;
            y_d     = rd_q.y;
          end
        endcase
      end
      S_ISSUE: begin
        if (ready) begin
          draw_d    = (op_q == OP_DRAW);
          jump_d    = (op_q == OP_JUMP);
          ack_cnt_d = '0;
          state_d   = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!ready) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == AKW'(ACK_TIMEOUT - 1)) begin
          // Drawer never acknowledged: flag it and treat the command as done
          ack_timeout_d = 1'b1;
          state_d       = S_ADVANCE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (ready) begin
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (addr_q == AW'(DEPTH - 1)) begin
          state_d = S_EOF;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EOF: state_d = S_FRAME_WAIT;
      S_FRAME_WAIT: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (timer_q >= TW'(FRAME_CYCLES - 1)) begin
          // timer_q + 1 cycles have elapsed since frame start, counting this one
          addr_d  = '0;
          timer_d = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_EOF) begin
      frame_count_d = frame_count_q + 1'b1;
    end
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_EOF);
  end

  assign x           = x_q;
  assign y           = y_q;
  assign draw        = draw_q;
  assign jump        = jump_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign ack_timeout = ack_timeout_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Bench for vector_list_sequencer: drawer model, frame-level command scoreboard
// and directed scenarios with hand-computed timing expectations.
module tb_vector_list_sequencer;

  localparam int unsigned DEPTH        = 256;
  localparam int unsigned AW           = 8;
  localparam int unsigned FRAME_CYCLES = 100;
  localparam int unsigned ACK_TIMEOUT  = 16;

  typedef struct {
    int op;
    int x;
    int y;
  } cmd_t;

  typedef struct {
    int op;
    int x;
    int y;
    int cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [25:0]   wr_data = '0;
  logic          run = 1'b0;
  logic          ready = 1'b1;
  logic [11:0]   x;
  logic [11:0]   y;
  logic          draw;
  logic          jump;
  logic          busy;
  logic          frame_done;
  logic [15:0]   frame_count;
  logic          ack_timeout;

  logic [25:0] img [DEPTH];
  cmd_t        exp_q [$];
  ev_t         seen [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 10;
  int lowcnt = 0;
  int rise_cyc = 0;
  int mfc = 0;
  int fd_n = 0;
  int fd_cyc = 0;
  logic prev_strobe = 1'b0;
  logic prev_fd = 1'b0;

  vector_list_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .FRAME_CYCLES(FRAME_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .ready(ready), .x(x), .y(y), .draw(draw), .jump(jump), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .ack_timeout(ack_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected command sequence of one frame: entries in order up to the first END
  // or the end of the list, NOPs skipped.
  function automatic void refill();
    cmd_t c;
    int   op;
    exp_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      op = int'(img[i][25:24]);
      if (op == 0) break;
      if (op != 3) begin
        c.op = op;
        c.x  = int'(img[i][23:12]);
        c.y  = int'(img[i][11:0]);
        exp_q.push_back(c);
      end
    end
  endfunction

  // Compare process plus drawer model (ready low for lat cycles per command)
  always @(negedge clk) begin
    cmd_t c;
    ev_t  e;
    if (!reset) begin
      prev_strobe = 1'b0;
      prev_fd     = 1'b0;
    end else begin
      if (draw || jump) begin
        chk("strobe_ready", int'(ready), 1);
        chk("strobe_one_hot", int'(draw && jump), 0);
        chk("strobe_width", int'(prev_strobe), 0);
        chk("strobe_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          c = exp_q.pop_front();
          chk("strobe_op", draw ? 2 : 1, c.op);
          chk("strobe_x", int'(x), c.x);
          chk("strobe_y", int'(y), c.y);
        end
        e.op  = draw ? 2 : 1;
        e.x   = int'(x);
        e.y   = int'(y);
        e.cyc = cyc;
        seen.push_back(e);
      end
      if (frame_done) begin
        chk("frame_done_width", int'(prev_fd), 0);
        chk("frame_cmds_left", exp_q.size(), 0);
        mfc = (mfc + 1) & 16'hFFFF;
        chk("frame_count", int'(frame_count), mfc);
        fd_n++;
        fd_cyc = cyc;
        refill();
      end
      prev_strobe = draw || jump;
      prev_fd     = frame_done;
      if (lowcnt > 0) begin
        lowcnt--;
        if (lowcnt == 0) begin
          ready    = 1'b1;
          rise_cyc = cyc;
        end
      end else if ((draw || jump) && lat > 0) begin
        ready  = 1'b0;
        lowcnt = lat;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int op, input int xv, input int yv);
    logic [25:0] d;
    d = {2'(op), 12'(xv), 12'(yv)};
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = d;
    img[addr] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    wr(0, 1, 50, 0);
    wr(1, 2, 0, 40);
    wr(2, 2, 50, 50);
    wr(3, 0, 0, 0);
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_n < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_done_reached", int'(fd_n >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_strobe(input int budget);
    int n = 0;
    while (!(draw || jump) && n < budget) begin
      tick();
      n++;
    end
    chk("strobe_reached", int'(draw || jump), 1);
  endtask

  initial begin
    int n;
    int fdc;
    for (int i = 0; i < int'(DEPTH); i++) img[i] = 26'h3000000;
    #2 reset = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_draw", int'(draw), 0);
    chk("rst_jump", int'(jump), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_ack_timeout", int'(ack_timeout), 0);
    reset = 1'b1;
    tick();

    // Basic list, two paced frames
    load_basic();
    lat = 10;
    refill();
    seen.delete();
    run = 1'b1;
    wait_fd(1, 500);
    chk("t1_strobe_count", seen.size(), 3);
    if (seen.size() >= 3) begin
      chk("t1_s0_op", seen[0].op, 1);
      chk("t1_s0_x", seen[0].x, 50);
      chk("t1_s0_y", seen[0].y, 0);
      chk("t1_s1_op", seen[1].op, 2);
      chk("t1_s1_x", seen[1].x, 0);
      chk("t1_s1_y", seen[1].y, 40);
      chk("t1_s2_op", seen[2].op, 2);
      chk("t1_s2_x", seen[2].x, 50);
      chk("t1_s2_y", seen[2].y, 50);
    end
    chk("t1_frame_count", int'(frame_count), 1);
    wait_fd(2, 500);
    run = 1'b0;
    chk("t2_frame_count", int'(frame_count), 2);
    chk("t2_strobe_count", seen.size(), 6);
    if (seen.size() >= 6) begin
      chk("t2_pacing_jump", seen[3].cyc - seen[0].cyc, 100);
      chk("t2_pacing_draw", seen[5].cyc - seen[2].cyc, 100);
    end
    wait_idle(20);
    exp_q.delete();

    // Drawer never acknowledges
    wr(0, 2, 7, 8);
    wr(1, 1, 9, 10);
    wr(2, 0, 0, 0);
    lat = 0;
    refill();
    seen.delete();
    run = 1'b1;
    wait_strobe(100);
    chk("t3_flag_at_strobe", int'(ack_timeout), 0);
    repeat (15) tick();
    chk("t3_flag_at_15", int'(ack_timeout), 0);
    tick();
    chk("t3_flag_at_16", int'(ack_timeout), 1);
    wait_fd(3, 500);
    run = 1'b0;
    chk("t3_strobe_count", seen.size(), 2);
    chk("t3_flag_sticky", int'(ack_timeout), 1);
    wait_idle(20);
    exp_q.delete();
    chk("t3_flag_after_idle", int'(ack_timeout), 1);

    // Full list with no END: implicit end of frame, immediate restart
    for (int i = 0; i < int'(DEPTH); i++) wr(i, 2, i, 255 - i);
    lat = 2;
    refill();
    seen.delete();
    run = 1'b1;
    wait_fd(4, 5000);
    fdc = fd_cyc;
    chk("t4_strobe_count", seen.size(), int'(DEPTH));
    wait_strobe(100);
    chk("t4_restart_gap", cyc - fdc, 5);
    chk("t4_restart_x", int'(x), 0);
    chk("t4_restart_y", int'(y), 255);
    run = 1'b0;
    wait_idle(100);
    exp_q.delete();

    // Stop while entry 1 is being drawn
    load_basic();
    lat = 10;
    refill();
    seen.delete();
    run = 1'b1;
    n = 0;
    while (seen.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_second_strobe", seen.size(), 2);
    repeat (3) tick();
    chk("t5_in_handshake", int'(ready), 0);
    run = 1'b0;
    exp_q.delete();
    wait_idle(50);
    chk("t5_stop_latency", cyc - rise_cyc, 2);
    repeat (5) tick();
    chk("t5_strobe_count", seen.size(), 2);
    chk("t5_frame_count", int'(frame_count), 4);

    // Reset while waiting for the drawer's acknowledge
    refill();
    seen.delete();
    run = 1'b1;
    wait_strobe(100);
    chk("t6_fc_before", int'(frame_count), 4);
    reset  = 1'b0;
    ready  = 1'b1;
    lowcnt = 0;
    #1;
    chk("t6_x", int'(x), 0);
    chk("t6_y", int'(y), 0);
    chk("t6_draw", int'(draw), 0);
    chk("t6_jump", int'(jump), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_frame_count", int'(frame_count), 0);
    run = 1'b0;
    mfc = 0;
    exp_q.delete();
    seen.delete();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    refill();
    run = 1'b1;
    wait_fd(5, 500);
    run = 1'b0;
    chk("t6_restart_count", seen.size(), 3);
    if (seen.size() >= 1) begin
      chk("t6_restart_op", seen[0].op, 1);
      chk("t6_restart_x", seen[0].x, 50);
    end
    chk("t6_frame_count_after", int'(frame_count), 1);
    wait_idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
